// File: rtl/opb_master_pkg.sv
// Shared types and constants for the single-word OPB master.
// Latency: none (declarations only).
// Backpressure: n/a.
package opb_master_pkg;

  localparam int OPB_AW  = 32;
  localparam int OPB_DW  = 32;
  localparam int OPB_BEW = OPB_DW / 8;
  localparam int RETRY_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    XFER = 2'b10,
    RESP = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_ERR        = 2'b01,
    ST_TIMEOUT    = 2'b10,
    ST_RETRY_FAIL = 2'b11
  } rsp_status_e;

endpackage

// File: rtl/opb_master_single_if.sv
// Command/response handshake plus OPB master-side bus signals.
// Latency: none (wiring only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready pairs.
interface opb_master_single_if;
  import opb_master_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rnw;
  logic [0:OPB_AW-1]  cmd_addr;
  logic [0:OPB_BEW-1] cmd_be;
  logic [0:OPB_DW-1]  cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:OPB_DW-1]  rsp_rdata;
  logic [1:0]        rsp_status;

  logic              M_request;
  logic              M_busLock;
  logic              M_select;
  logic              M_RNW;
  logic              M_seqAddr;
  logic [0:OPB_AW-1]  M_ABus;
  logic [0:OPB_BEW-1] M_BE;
  logic [0:OPB_DW-1]  M_DBus;

  logic              OPB_MGrant;
  logic              OPB_xferAck;
  logic              OPB_errAck;
  logic              OPB_retry;
  logic              OPB_timeout;
  logic [0:OPB_DW-1]  OPB_DBus;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata, rsp_ready,
    input  OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout, OPB_DBus,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
    output M_request, M_busLock, M_select, M_RNW, M_seqAddr, M_ABus, M_BE, M_DBus
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata, rsp_ready,
    output OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout, OPB_DBus,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
    input  M_request, M_busLock, M_select, M_RNW, M_seqAddr, M_ABus, M_BE, M_DBus
  );

endinterface

// File: rtl/opb_master_single.sv
// Single-word OPB master: one read/write per command, handles grant, retry, errAck, timeout.
// Latency: 3 cycles min command-to-response (accept -> REQ -> XFER -> RESP).
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. Watchdog via OPB_MASTER_WDOG_EN.
module opb_master_single
  import opb_master_pkg::*;
#(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_MAX_RETRY  = 4
`ifdef OPB_MASTER_WDOG_EN
  , parameter int C_WDOG_CYCLES = 255
`endif
) (
  input  logic                 OPB_Clk,
  input  logic                 OPB_Rst_n,
  opb_master_single_if.master  bus
);

  localparam logic [RETRY_W-1:0] MAX_RETRY = RETRY_W'(C_MAX_RETRY);

  state_e                  state_q, state_d;
  logic                    rnw_q, rnw_d;
  logic [0:C_OPB_AWIDTH-1] addr_q, addr_d;
  logic [0:OPB_BEW-1]      be_q, be_d;
  logic [0:C_OPB_DWIDTH-1] wdata_q, wdata_d;
  logic [0:C_OPB_DWIDTH-1] rdata_q, rdata_d;
  rsp_status_e             status_q, status_d;
  logic [RETRY_W-1:0]      retry_cnt_q, retry_cnt_d;
  logic                    sel;

`ifdef OPB_MASTER_WDOG_EN
  localparam int WDOG_W = ($clog2(C_WDOG_CYCLES + 1) > 8) ? $clog2(C_WDOG_CYCLES + 1) : 8;
  // Counter holds the number of XFER cycles already spent; the last allowed one is LIMIT-1.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(C_WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  // Watchdog counter register
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) wdog_cnt_q <= '0;
    else            wdog_cnt_q <= wdog_cnt_d;
  end
`endif

  // State and command/response registers
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q     <= IDLE;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      status_q    <= ST_OK;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  // Next-state: command latch, arbitration, slave event priority resolution
  always_comb begin
    state_d     = state_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    retry_cnt_d = retry_cnt_q;
`ifdef OPB_MASTER_WDOG_EN
    wdog_cnt_d  = wdog_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          rnw_d       = bus.cmd_rnw;
          addr_d      = bus.cmd_addr;
          be_d        = bus.cmd_be;
          wdata_d     = bus.cmd_wdata;
          rdata_d     = '0;
          status_d    = ST_OK;
          retry_cnt_d = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.OPB_MGrant) begin
          state_d = XFER;
`ifdef OPB_MASTER_WDOG_EN
          wdog_cnt_d = '0;
`endif
        end
      end
      XFER: begin
`ifdef OPB_MASTER_WDOG_EN
        wdog_cnt_d = wdog_cnt_q + 1'b1;
`endif
        if (bus.OPB_timeout) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end else if (bus.OPB_errAck) begin
          status_d = ST_ERR;
          state_d  = RESP;
        end else if (bus.OPB_retry) begin
          retry_cnt_d = retry_cnt_q + 1'b1;
          if (retry_cnt_d == MAX_RETRY) begin
            status_d = ST_RETRY_FAIL;
            state_d  = RESP;
          end else begin
            state_d  = REQ;
          end
        end else if (bus.OPB_xferAck) begin
          status_d = ST_OK;
          if (rnw_q) rdata_d = bus.OPB_DBus;
          state_d  = RESP;
`ifdef OPB_MASTER_WDOG_EN
        end else if (wdog_cnt_q == WDOG_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: OR-bus signals forced to zero whenever not selected
  always_comb begin
    sel            = (state_q == XFER);
    bus.cmd_ready  = (state_q == IDLE) && OPB_Rst_n;
    bus.M_request  = (state_q == REQ);
    bus.M_select   = sel;
    bus.M_RNW      = sel && rnw_q;
    bus.M_busLock  = 1'b0;
    bus.M_seqAddr  = 1'b0;
    bus.M_ABus     = sel ? addr_q : '0;
    bus.M_BE       = sel ? be_q : '0;
    bus.M_DBus     = (sel && !rnw_q) ? wdata_q : '0;
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_rdata  = (state_q == RESP) ? rdata_q : '0;
    bus.rsp_status = (state_q == RESP) ? status_q : ST_OK;
  end

endmodule
